// File: rtl/pipe_reg_file_pkg.sv
// Shared constants and helpers for the pipelined register file: default sizes,
// address-width derivation and the hard-wired zero register index.
package pipe_reg_file_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int NRP_DEF  = 2;
  localparam int REG_ZERO = 0;

  // Smallest w with 2**w >= n; NREG is a power of two, so this is exact.
  function automatic int aw_of(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/pipe_reg_file_if.sv
// Read/write/scoreboard bus of the register file; master drives addresses and
// commands, slave (the register file) returns read data and busy status.
interface pipe_reg_file_if #(
  parameter int XLEN = pipe_reg_file_pkg::XLEN_DEF,
  parameter int NREG = pipe_reg_file_pkg::NREG_DEF,
  parameter int NRP  = pipe_reg_file_pkg::NRP_DEF
) ();
  import pipe_reg_file_pkg::*;

  localparam int AW = aw_of(NREG);

  logic [NRP*AW-1:0]   raddr;
  logic [NRP*XLEN-1:0] rdata;
  logic [NRP-1:0]      rbusy;
  logic                we;
  logic [AW-1:0]       waddr;
  logic [XLEN-1:0]     wdata;
  logic                alloc;
  logic [AW-1:0]       alloc_addr;
  logic                flush;
  logic [AW:0]         busy_cnt;

  modport master (
    output raddr, we, waddr, wdata, alloc, alloc_addr, flush,
    input  rdata, rbusy, busy_cnt
  );

  modport slave (
    input  raddr, we, waddr, wdata, alloc, alloc_addr, flush,
    output rdata, rbusy, busy_cnt
  );

endinterface

// File: rtl/pipe_reg_file_sb.sv
// Pending-writer scoreboard: one bit per register, set by alloc, cleared by the
// matching write or by flush, plus a registered population count.
module pipe_reg_sb
  import pipe_reg_file_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int AW   = aw_of(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alloc,
  input  logic [AW-1:0]   alloc_addr,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic            flush,
  output logic [NREG-1:0] pend,
  output logic [AW:0]     busy_cnt
);

  logic [NREG-1:0] pend_nxt;
  logic [AW:0]     cnt_nxt;

  // NOTE: every always_comb output gets a default first; a path that skips an
  // assignment would otherwise infer a latch.
  always_comb begin
    pend_nxt = pend;
    if (we) pend_nxt[waddr] = 1'b0;
    // A new producer issued in the same cycle as the old one retires stays outstanding.
    if (flush)      pend_nxt = '0;
    else if (alloc) pend_nxt[alloc_addr] = 1'b1;
    pend_nxt[REG_ZERO] = 1'b0;

    cnt_nxt = '0;
    for (int i = 0; i < NREG; i++) cnt_nxt = cnt_nxt + (AW+1)'(pend_nxt[i]);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend     <= '0;
      busy_cnt <= '0;
    end else begin
      pend     <= pend_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/pipe_reg_file.sv
// Multi-port register file with zero register, optional write-to-read bypass
// and a pending-writer scoreboard for issue-stage hazard checks.
module pipe_reg_file
  import pipe_reg_file_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int NRP    = NRP_DEF,
  parameter int BYPASS = 1
) (
  input logic            clk,
  input logic            rst,
  pipe_reg_file_if.slave bus
);

  localparam int AW = aw_of(NREG);

  logic [XLEN-1:0]     mem [NREG];
  logic [NREG-1:0]     pend;
  logic                wr_hit;
  logic [NRP*XLEN-1:0] rdata_w;
  logic [NRP-1:0]      rbusy_w;

  assign wr_hit = bus.we && (bus.waddr != AW'(REG_ZERO));

  // NOTE: the storage array is reset on purpose: every register must read zero
  // while reset is asserted, which rules out a plain RAM macro here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (wr_hit) begin
      mem[bus.waddr] <= bus.wdata;
    end
  end

  pipe_reg_sb #(.NREG(NREG), .AW(AW)) u_sb (
    .clk        (clk),
    .rst        (rst),
    .alloc      (bus.alloc && (bus.alloc_addr != AW'(REG_ZERO))),
    .alloc_addr (bus.alloc_addr),
    .we         (wr_hit),
    .waddr      (bus.waddr),
    .flush      (bus.flush),
    .pend       (pend),
    .busy_cnt   (bus.busy_cnt)
  );

  always_comb begin
    rdata_w = '0;
    rbusy_w = '0;
    for (int p = 0; p < NRP; p++) begin
      logic [AW-1:0] ra;
      logic          fwd;
      ra  = bus.raddr[p*AW +: AW];
      fwd = (BYPASS != 0) && wr_hit && (bus.waddr == ra);
      rdata_w[p*XLEN +: XLEN] = fwd ? bus.wdata : mem[ra];
      // A retiring write hides the busy flag unless a new producer claims the register.
      rbusy_w[p] = pend[ra] && !(fwd && !(bus.alloc && (bus.alloc_addr == ra)));
    end
  end

  assign bus.rdata = rdata_w;
  assign bus.rbusy = rbusy_w;

endmodule

// File: tb/tb_pipe_reg_file.sv
// Self-checking bench: a bypass and a non-bypass instance see identical stimulus
// and are compared against an array-based behavioural model.
module tb_pipe_reg_file;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRP  = 2;
  localparam int AW   = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [NRP*AW-1:0] raddr;
  logic              we;
  logic [AW-1:0]     waddr;
  logic [XLEN-1:0]   wdata;
  logic              alloc;
  logic [AW-1:0]     alloc_addr;
  logic              flush;

  pipe_reg_file_if #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP)) if1 ();
  pipe_reg_file_if #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP)) if0 ();

  assign if1.raddr = raddr;  assign if0.raddr = raddr;
  assign if1.we = we;        assign if0.we = we;
  assign if1.waddr = waddr;  assign if0.waddr = waddr;
  assign if1.wdata = wdata;  assign if0.wdata = wdata;
  assign if1.alloc = alloc;  assign if0.alloc = alloc;
  assign if1.alloc_addr = alloc_addr;  assign if0.alloc_addr = alloc_addr;
  assign if1.flush = flush;  assign if0.flush = flush;

  pipe_reg_file #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP), .BYPASS(1)) u_byp (
    .clk(clk), .rst(rst), .bus(if1)
  );
  pipe_reg_file #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP), .BYPASS(0)) u_nob (
    .clk(clk), .rst(rst), .bus(if0)
  );

  // Behavioural model: architectural register values and outstanding producers.
  logic [XLEN-1:0] mem_m [NREG];
  bit              pend_m [NREG];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] ra_of(input int p);
    logic [NRP*AW-1:0] v;
    v = raddr;
    return v[p*AW +: AW];
  endfunction

  function automatic bit same_cycle_write(input logic [AW-1:0] a);
    return we && (waddr != 0) && (waddr == a);
  endfunction

  function automatic logic [XLEN-1:0] exp_rdata(input int p, input bit byp);
    logic [AW-1:0] a;
    a = ra_of(p);
    if (byp && same_cycle_write(a)) return wdata;
    return (a == 0) ? '0 : mem_m[a];
  endfunction

  function automatic logic exp_rbusy(input int p, input bit byp);
    logic [AW-1:0] a;
    a = ra_of(p);
    if (!pend_m[a]) return 1'b0;
    if (byp && same_cycle_write(a) && !(alloc && alloc_addr == a)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int exp_cnt();
    int n;
    n = 0;
    foreach (pend_m[i]) n += int'(pend_m[i]);
    return n;
  endfunction

  task automatic model_reset();
    foreach (mem_m[i]) mem_m[i] = '0;
    foreach (pend_m[i]) pend_m[i] = 1'b0;
  endtask

  task automatic check_all(input string tag);
    for (int p = 0; p < NRP; p++) begin
      chk($sformatf("%s.byp.rdata%0d", tag, p), 64'(if1.rdata[p*XLEN +: XLEN]), 64'(exp_rdata(p, 1'b1)));
      chk($sformatf("%s.nob.rdata%0d", tag, p), 64'(if0.rdata[p*XLEN +: XLEN]), 64'(exp_rdata(p, 1'b0)));
      chk($sformatf("%s.byp.rbusy%0d", tag, p), 64'(if1.rbusy[p]), 64'(exp_rbusy(p, 1'b1)));
      chk($sformatf("%s.nob.rbusy%0d", tag, p), 64'(if0.rbusy[p]), 64'(exp_rbusy(p, 1'b0)));
    end
    chk({tag, ".byp.cnt"}, 64'(if1.busy_cnt), 64'(exp_cnt()));
    chk({tag, ".nob.cnt"}, 64'(if0.busy_cnt), 64'(exp_cnt()));
  endtask

  // Advance one rising edge and apply the architectural effect of the inputs.
  task automatic tick();
    @(posedge clk);
    #1;
    if (we && waddr != 0) begin
      mem_m[waddr]  = wdata;
      pend_m[waddr] = 1'b0;
    end
    if (flush) foreach (pend_m[i]) pend_m[i] = 1'b0;
    else if (alloc && alloc_addr != 0) pend_m[alloc_addr] = 1'b1;
  endtask

  task automatic idle();
    we = 0; alloc = 0; flush = 0;
  endtask

  initial begin
    raddr = '0; we = 0; waddr = '0; wdata = '0;
    alloc = 0; alloc_addr = '0; flush = 0;
    model_reset();

    // Reset state on every register, both ports.
    #12 rst = 1'b1;
    for (int i = 0; i < NREG; i++) begin
      raddr = {AW'(i), AW'(i)};
      #1 check_all($sformatf("rst_x%0d", i));
    end

    // Same-cycle write to x5: forwarded only by the bypass instance.
    we = 1; waddr = 5; wdata = 32'hDEADBEEF; raddr = {AW'(6), AW'(5)};
    #1 check_all("wr5_same");
    chk("wr5_byp_fwd", 64'(if1.rdata[31:0]), 64'h0000_0000_DEAD_BEEF);
    chk("wr5_nob_old", 64'(if0.rdata[31:0]), 64'h0);
    tick();
    idle();
    #1 check_all("wr5_next");
    chk("wr5_nob_next", 64'(if0.rdata[31:0]), 64'h0000_0000_DEAD_BEEF);

    // Register zero ignores writes and allocation.
    we = 1; waddr = 0; wdata = 32'hFFFFFFFF; raddr = '0;
    #1 check_all("wr0_same");
    tick();
    idle(); alloc = 1; alloc_addr = 0;
    #1 check_all("alloc0");
    tick();
    idle();
    #1 check_all("x0_after");
    chk("x0_cnt", 64'(if1.busy_cnt), 64'h0);

    // Scoreboard set, count and set-wins on simultaneous alloc + write.
    alloc = 1; alloc_addr = 7; tick();
    alloc_addr = 9; tick();
    idle(); raddr = {AW'(9), AW'(7)};
    #1 check_all("alloc79");
    chk("alloc79_cnt", 64'(if1.busy_cnt), 64'd2);
    chk("alloc7_busy", 64'(if1.rbusy[0]), 64'd1);
    alloc = 1; alloc_addr = 7; we = 1; waddr = 7; wdata = 32'h0000A5A5;
    #1 check_all("aw7_same");
    chk("aw7_byp_busy", 64'(if1.rbusy[0]), 64'd1);
    tick();
    idle();
    #1 check_all("aw7_next");
    chk("aw7_data", 64'(if0.rdata[31:0]), 64'h0000A5A5);
    chk("aw7_cnt", 64'(if0.busy_cnt), 64'd2);

    // Retiring write on x9 hides busy only with bypass.
    we = 1; waddr = 9; wdata = 32'h99;
    #1 check_all("ret9_same");
    chk("ret9_byp_busy", 64'(if1.rbusy[1]), 64'd0);
    chk("ret9_nob_busy", 64'(if0.rbusy[1]), 64'd1);
    tick();
    idle();
    #1 check_all("ret9_next");

    // Flush beats a same-cycle alloc.
    alloc = 1;
    alloc_addr = 3; tick();
    alloc_addr = 4; tick();
    alloc_addr = 8; tick();
    alloc_addr = 10; flush = 1; raddr = {AW'(3), AW'(10)};
    #1 check_all("flush_same");
    tick();
    idle();
    #1 check_all("flush_next");
    chk("flush_cnt", 64'(if1.busy_cnt), 64'd0);
    chk("flush_x10", 64'(if1.rbusy[0]), 64'd0);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      raddr      = NRP*AW'($urandom);
      we         = 1'($urandom);
      waddr      = AW'($urandom);
      wdata      = $urandom;
      alloc      = 1'($urandom);
      alloc_addr = AW'($urandom);
      flush      = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) raddr[AW-1:0] = waddr;
      #1 check_all($sformatf("rnd%0d", n));
      tick();
    end

    // Asynchronous reset mid-cycle clears storage without a clock edge.
    idle(); we = 1; waddr = 12; wdata = 32'h1234; alloc = 1; alloc_addr = 12;
    tick();
    idle(); raddr = {AW'(12), AW'(12)};
    #1 check_all("x12_pre");
    chk("x12_written", 64'(if0.rdata[31:0]), 64'h1234);
    #2 rst = 1'b0;
    model_reset();
    #1 check_all("arst_now");
    chk("arst_x12", 64'(if1.rdata[31:0]), 64'h0);
    chk("arst_cnt", 64'(if0.busy_cnt), 64'h0);

    // A write held during reset is discarded.
    we = 1; waddr = 12; wdata = 32'hBEEF; raddr = {AW'(13), AW'(13)};
    @(posedge clk);
    #1 idle();
    #1 rst = 1'b1;
    raddr = {AW'(12), AW'(12)};
    #1 check_all("rst_discard");
    chk("rst_discard_x12", 64'(if0.rdata[31:0]), 64'h0);

    // First write after reset is accepted.
    we = 1; waddr = 12; wdata = 32'h5678;
    tick();
    idle();
    #1 check_all("post_rst_wr");
    chk("post_rst_x12", 64'(if0.rdata[31:0]), 64'h5678);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench did not finish");
  end

endmodule
